// File: rtl/pkt_len_limit.sv
// Packet length limiter: forwards up to len_q samples per packet, forces tlast on
// the last allowed sample, drops the overflow and counts truncated packets.
module pkt_len_limit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MAX_L = 32,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned LEN_W = $clog2(MAX_L + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [CNT_W-1:0] trunc_cnt,
  output logic             trunc_pulse
);

  typedef enum logic {PASS, DROP} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   cnt, cnt_nxt;
  logic [LEN_W-1:0]   len_q, len_q_nxt;
  logic [LEN_W-1:0]   len_sel, len_cur;
  logic [WIDTH-1:0]   tdata_nxt;
  logic               tlast_nxt, tvalid_nxt;
  logic [CNT_W-1:0]   trunc_cnt_nxt;
  logic               pulse_nxt;
  logic               acc, at_lim;

  // DROP sinks everything; PASS accepts whenever the output slot frees up
  assign i_tready = (state == DROP) | ~o_tvalid | o_tready;
  assign acc      = i_tvalid & i_tready;

  // Illegal requests fall back to the longest legal packet
  assign len_sel = (len == '0 || 32'(len) > MAX_L) ? LEN_W'(MAX_L) : len;
  assign len_cur = (cnt == '0) ? len_sel : len_q;
  assign at_lim  = (cnt == len_cur - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PASS;
      cnt         <= '0;
      len_q       <= LEN_W'(MAX_L);
      o_tdata     <= '0;
      o_tlast     <= 1'b0;
      o_tvalid    <= 1'b0;
      trunc_cnt   <= '0;
      trunc_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      len_q       <= len_q_nxt;
      o_tdata     <= tdata_nxt;
      o_tlast     <= tlast_nxt;
      o_tvalid    <= tvalid_nxt;
      trunc_cnt   <= trunc_cnt_nxt;
      trunc_pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    len_q_nxt     = len_q;
    tdata_nxt     = o_tdata;
    tlast_nxt     = o_tlast;
    tvalid_nxt    = o_tvalid & ~o_tready;
    trunc_cnt_nxt = trunc_cnt;
    pulse_nxt     = 1'b0;
    case (state)
      PASS: begin
        if (acc) begin
          if (cnt == '0) len_q_nxt = len_sel;
          tdata_nxt  = i_tdata;
          tlast_nxt  = i_tlast | at_lim;
          tvalid_nxt = 1'b1;
          if (i_tlast) begin
            cnt_nxt = '0;
          end else if (at_lim) begin
            cnt_nxt   = '0;
            state_nxt = DROP;
            pulse_nxt = 1'b1;
            if (trunc_cnt != '1) trunc_cnt_nxt = trunc_cnt + CNT_W'(1);
          end else begin
            cnt_nxt = cnt + LEN_W'(1);
          end
        end
      end
      DROP: begin
        if (acc && i_tlast) state_nxt = PASS;
      end
      default: state_nxt = PASS;
    endcase
  end

endmodule

// File: tb/tb_pkt_len_limit.sv
// Randomized bench for pkt_len_limit against a per-packet reference model.
module tb_pkt_len_limit;
  localparam int unsigned MAX_L   = 32;
  localparam int unsigned CNT_MAX = 3;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic        clk, reset;
  logic [5:0]  len;
  logic [31:0] i_tdata;
  logic        i_tlast, i_tvalid, i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast, o_tvalid, o_tready;
  logic [1:0]  trunc_cnt;
  logic        trunc_pulse;

  pkt_len_limit #(.WIDTH(32), .MAX_L(MAX_L), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .len(len),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .trunc_cnt(trunc_cnt), .trunc_pulse(trunc_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t oq[$];
  int k = 0;
  int cur_l = MAX_L;
  int total = 0;
  int pulse_seen = 0;
  logic exp_pulse = 1'b0;
  logic last_acc = 1'b0;
  int next_d = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each packet keeps its first L samples, L taken from len at its first sample
  task automatic model_accept(input logic [31:0] d, input logic tl);
    exp_t e;
    if (k == 0) cur_l = (len == 0 || int'(len) > MAX_L) ? MAX_L : int'(len);
    if (k < cur_l) begin
      e.d = d;
      e.l = tl || (k == cur_l - 1);
      oq.push_back(e);
      if (k == cur_l - 1 && !tl) begin
        total++;
        exp_pulse = 1'b1;
      end
    end
    k = tl ? 0 : k + 1;
  endtask

  task automatic tick();
    logic exp_valid, exp_rdy, acc_now, ohs;
    int   exp_cnt;
    #4;
    exp_valid = (oq.size() != 0);
    chk("o_tvalid", 32'(o_tvalid), 32'(exp_valid));
    if (exp_valid && o_tvalid) begin
      chk("o_tdata", o_tdata, oq[0].d);
      chk("o_tlast", 32'(o_tlast), 32'(oq[0].l));
    end
    exp_rdy = (k >= cur_l) || !exp_valid || o_tready;
    chk("i_tready", 32'(i_tready), 32'(exp_rdy));
    chk("trunc_pulse", 32'(trunc_pulse), 32'(exp_pulse));
    exp_cnt = (total > CNT_MAX) ? CNT_MAX : total;
    chk("trunc_cnt", 32'(trunc_cnt), 32'(exp_cnt));
    if (trunc_pulse) pulse_seen++;
    acc_now = i_tvalid && i_tready;
    ohs = o_tvalid && o_tready;
    @(posedge clk);
    exp_pulse = 1'b0;
    if (ohs && oq.size() != 0) void'(oq.pop_front());
    if (acc_now) begin
      model_accept(i_tdata, i_tlast);
      next_d++;
    end
    last_acc = acc_now;
    #1;
  endtask

  task automatic do_reset();
    i_tvalid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    oq.delete();
    k = 0;
    cur_l = MAX_L;
    total = 0;
    exp_pulse = 1'b0;
    reset = 1'b0;
    chk("rst_o_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_o_tlast", 32'(o_tlast), 32'd0);
    chk("rst_o_tdata", o_tdata, 32'd0);
    chk("rst_trunc_cnt", 32'(trunc_cnt), 32'd0);
    chk("rst_trunc_pulse", 32'(trunc_pulse), 32'd0);
  endtask

  // rmode: 0 = always ready/valid, 1 = ready pattern 1,0,0, 2 = random
  task automatic send_pkt(input int n, input int len_a, input int chg_at, input int len_b,
                          input int abort_at, input int rmode);
    int sent = 0;
    int cyc = 0;
    len = 6'(len_a);
    i_tvalid = 1'b0;
    while (sent < n && cyc < 500) begin
      if (sent == chg_at) len = 6'(len_b);
      if (sent == abort_at) begin
        do_reset();
        return;
      end
      if (!i_tvalid) i_tvalid = (rmode == 0) || ($urandom_range(3) != 0);
      i_tdata = 32'(next_d);
      i_tlast = (sent == n - 1);
      case (rmode)
        0:       o_tready = 1'b1;
        1:       o_tready = (cyc % 3 == 0);
        default: o_tready = 1'($urandom_range(1));
      endcase
      tick();
      if (last_acc) begin
        sent++;
        i_tvalid = 1'b0;
      end
      cyc++;
    end
    i_tvalid = 1'b0;
    checks++;
    assert (sent == n) else begin
      failures++;
      $error("FAIL send_timeout observed=%0d expected=%0d", sent, n);
    end
  endtask

  task automatic drain();
    int c = 0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    while (oq.size() != 0 && c < 20) begin
      tick();
      c++;
    end
    tick();
    chk("drain_empty", 32'(oq.size()), 32'd0);
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    reset = 1'b1;
    len = 6'd8;
    i_tdata = '0;
    i_tlast = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    do_reset();

    // exact length
    next_d = 1;
    send_pkt(8, 8, -1, 0, -1, 0);
    drain();
    chk("exact_cnt", 32'(trunc_cnt), 32'd0);

    // truncation then short packet
    next_d = 1;
    send_pkt(10, 4, -1, 0, -1, 0);
    send_pkt(3, 4, -1, 0, -1, 0);
    drain();
    chk("trunc_cnt_1", 32'(trunc_cnt), 32'd1);

    // illegal len then short packet
    do_reset();
    send_pkt(40, 0, -1, 0, -1, 0);
    drain();
    chk("illegal_cnt", 32'(trunc_cnt), 32'd1);
    send_pkt(2, 5, -1, 0, -1, 0);
    drain();
    chk("short_cnt", 32'(trunc_cnt), 32'd1);

    // back-pressure
    send_pkt(6, 6, -1, 0, -1, 1);
    drain();

    // mid-packet len change, then reset mid-packet, then a fresh packet
    do_reset();
    send_pkt(6, 4, 2, 2, -1, 0);
    drain();
    chk("len_change_cnt", 32'(trunc_cnt), 32'd1);
    send_pkt(6, 4, -1, 0, 2, 0);
    chk("abort_cnt", 32'(trunc_cnt), 32'd0);
    send_pkt(5, 3, -1, 0, -1, 2);
    drain();

    // counter saturation with len=1
    do_reset();
    pulse_seen = 0;
    for (int i = 0; i < 5; i++) begin
      send_pkt(3, 1, -1, 0, -1, 2);
      drain();
      chk("sat_cnt", 32'(trunc_cnt), 32'(sat_exp[i]));
    end
    chk("sat_pulses", 32'(pulse_seen), 32'd5);

    // random packets and lengths
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send_pkt(int'($urandom_range(1, 40)), int'($urandom_range(0, 63)), -1, 0, -1, 2);
      if ($urandom_range(3) == 0) drain();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
